ethernet_receive_slot_manager: RTL and testbench
================================================

# ethernet_receive_slot_manager

Allocates and sequences the receive-queue slots shared between `ethernet_packet_parser` (the writer) and the downstream forwarding engine (the reader). It offers exactly one free slot to the parser and tracks each slot through FREE, FILLING, READY and DRAINING. Slots carrying good frames are queued to the reader in completion order. Slots carrying bad-CRC frames are recycled immediately.

## Interface
- `RECEIVE_QUE_SLOTS`, default 4: number of slots (≥2); must match the parser instance.
- `SLOT_INDEX_WIDTH`, default `$clog2(RECEIVE_QUE_SLOTS)`: width of slot index ports.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `receive_slot_enable`  out  N  one-hot offer of one free slot to the parser; all-zero when no slot is free.
- `packet_data_valid`  in  N  parser byte write, per slot; the first one seen claims the slot.
- `good_packet`  in  N  parser completion pulse, CRC good.
- `bad_packet`  in  N  parser completion pulse, CRC bad.
- `ready_slot`  out  SLOT_INDEX_WIDTH  index of the oldest READY slot.
- `ready_slot_valid`  out  1  `ready_slot` is valid.
- `ready_slot_ready`  in  1  reader accepts `ready_slot`.
- `release_slot`  in  SLOT_INDEX_WIDTH  index of the slot the reader has finished draining.
- `release_slot_enable`  in  1  `release_slot` is valid for one cycle.
- `free_slot_count`  out  SLOT_INDEX_WIDTH+1  number of FREE slots.
- `dropped_packet_count`  out  16  saturating count of `bad_packet` pulses.
- `protocol_error`  out  1  sticky flag for an illegal event; cleared only by reset.

## Operation
- Each slot has a 2-bit state: FREE, FILLING, READY or DRAINING. Reset puts every slot in FREE.
- **Offer.** `receive_slot_enable` is registered: a one-hot of the lowest-indexed FREE slot, computed from the current slot states. It is never multi-hot.
- **Claim.** `packet_data_valid[k]` while slot k is FREE moves slot k to FILLING.
  - Further `packet_data_valid[k]` while slot k is FILLING is legal and has no effect.
- **Good completion.** `good_packet[k]` while slot k is FILLING moves it to READY and pushes k into the order FIFO (depth N).
- **Bad completion.** `bad_packet[k]` while slot k is FILLING moves it to FREE and increments `dropped_packet_count`, saturating at 0xFFFF.
- **Pop.** A cycle with `ready_slot_valid` and `ready_slot_ready` both high pops the FIFO head and moves that slot from READY to DRAINING.
  - `ready_slot` and `ready_slot_valid` must hold stable until the pop.
- **Release.** `release_slot_enable` with slot `release_slot` in DRAINING moves that slot to FREE.
- **Illegal events.** Each of the following is ignored and sets `protocol_error`:
  - `good_packet` or `bad_packet` on a slot that is not FILLING;
  - `good_packet[k]` and `bad_packet[k]` in the same cycle;
  - `packet_data_valid` on a READY or DRAINING slot;
  - a release of a slot that is not DRAINING;
  - `release_slot` ≥ N.
- **Simultaneous events.** Events in the same cycle on different slots all take effect.
  - FIFO push and pop in the same cycle are allowed; occupancy is unchanged.
  - The FIFO cannot overflow because each slot is enqueued at most once.
  - Overflow is still checked; an attempted push into a full FIFO sets `protocol_error` and is not performed.
- **Reset mid-operation.** All slots return to FREE, the FIFO empties, and counters and flags clear. Any frame in flight is discarded.

## Timing
- Reset values:
  - `receive_slot_enable` = 0;
  - `ready_slot_valid` = 0 and `ready_slot` = 0;
  - `free_slot_count` = 0;
  - `dropped_packet_count` = 0 and `protocol_error` = 0.
- First cycle after reset deasserts: `receive_slot_enable` = 1 (slot 0) and `free_slot_count` = N.
- All outputs are registered, with no combinational input-to-output path.
- State changes on the edge that samples the event. `receive_slot_enable` and `free_slot_count` reflect the new state one cycle later.
- A claim on edge E removes slot k from the offer from cycle E+1. The parser reselects its slot in IDLE, so no double-claim occurs.
- `good_packet` sampled on edge E makes `ready_slot_valid` high in cycle E+1 if the FIFO was empty. Push-to-valid latency is 1 cycle.
- A pop on edge E exposes the next head in cycle E+1 (zero bubble).
- A release on edge E makes the slot eligible for the offer at E+1, visible on `receive_slot_enable` from cycle E+2.

## Structure
- Shared package `ethernet_switch_pkg` holds:
  - the enum `slot_state_type` {S_SLOT_FREE, S_SLOT_FILLING, S_SLOT_READY, S_SLOT_DRAINING};
  - the localparam `DROP_COUNT_WIDTH` = 16.
- Sub-module `slot_index_fifo`: a synchronous FIFO, parameterised by depth and width, with push, pop, full, empty, head data and count.
- Slot-state update, offer priority encoder and error logic live in the top module.

## Test plan
- **Reset, then idle (N=4).** Expect `receive_slot_enable`=4'b0001, `free_slot_count`=4, `ready_slot_valid`=0.
- **Good frame, normal flow.** Drive `packet_data_valid[0]` for 64 cycles, then `good_packet[0]`.
  - Next cycle: `ready_slot`=0, `ready_slot_valid`=1.
  - After the claim: offer is 4'b0010.
  - Accept, then release 0: `free_slot_count` returns to 4.
- **Bad frame.** Claim slot 0, then pulse `bad_packet[0]`. Expect slot 0 offered again two cycles later, `dropped_packet_count`=1 and an empty FIFO.
- **Order preserved.** Claim slots 0,1,2 and complete them good in order 2,0,1. Expect pops yield 2,0,1; then `receive_slot_enable`=4'b1000 and `free_slot_count`=1.
- **Full occupancy.** Fill all 4 slots good with no pops. Expect `receive_slot_enable`=0 and `free_slot_count`=0.
  - Then, in one cycle, pop slot 0 and release nothing. Expect no overflow and no error.
- **Illegal events and reset.** Expect `protocol_error`=1 and all states unchanged after each of:
  - `good_packet[3]` on a FREE slot;
  - a release of a READY slot;
  - simultaneous `good_packet[1]` and `bad_packet[1]`.

  Assert `reset` mid-frame: the next cycle shows all slots FREE and the error cleared.

Source files
------------

// File: rtl/ethernet_switch_pkg.sv
// ethernet_switch_pkg: shared slot-state enum and drop-counter width
package ethernet_switch_pkg;
  typedef enum logic [1:0] {
    S_SLOT_FREE,
    S_SLOT_FILLING,
    S_SLOT_READY,
    S_SLOT_DRAINING
  } slot_state_type;
  localparam int DROP_COUNT_WIDTH = 16;
endpackage

// File: rtl/slot_index_fifo.sv
// slot_index_fifo: sync fifo (clock/reset; multi-lane push+data, pop; full, empty, head, count)
module slot_index_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int LANES = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [LANES-1:0]               push,
  input  logic [LANES-1:0][WIDTH-1:0]    push_data,
  input  logic                           pop,
  output logic                           full,
  output logic                           empty,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] rd;
  logic [LANES-1:0] take;
  logic [LANES-1:0][PW-1:0] widx;
  logic pop_ok;
  int n;
  assign pop_ok = pop && !empty;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign head = mem[rd];
  always_comb begin
    n = 0;
    take = '0;
    widx = '0;
    for (int i = 0; i < LANES; i++) begin
      take[i] = push[i] && (int'(count) + n < DEPTH + int'(pop_ok));
      widx[i] = PW'((int'(rd) + int'(count) + n) % DEPTH);
      n = n + int'(take[i]);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mem <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (take[i]) mem[widx[i]] <= push_data[i];
      rd <= pop_ok ? PW'((int'(rd) + 1) % DEPTH) : rd;
      count <= CW'(int'(count) + n - int'(pop_ok));
    end
  end
endmodule

// File: rtl/ethernet_receive_slot_manager.sv
// ethernet_receive_slot_manager: slot FSMs, free-slot offer, ready-order fifo, drop count, sticky protocol error
module ethernet_receive_slot_manager import ethernet_switch_pkg::*; #(
  parameter int RECEIVE_QUE_SLOTS = 4,
  parameter int SLOT_INDEX_WIDTH = $clog2(RECEIVE_QUE_SLOTS)
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic [RECEIVE_QUE_SLOTS-1:0]  receive_slot_enable,
  input  logic [RECEIVE_QUE_SLOTS-1:0]  packet_data_valid,
  input  logic [RECEIVE_QUE_SLOTS-1:0]  good_packet,
  input  logic [RECEIVE_QUE_SLOTS-1:0]  bad_packet,
  output logic [SLOT_INDEX_WIDTH-1:0]   ready_slot,
  output logic                          ready_slot_valid,
  input  logic                          ready_slot_ready,
  input  logic [SLOT_INDEX_WIDTH-1:0]   release_slot,
  input  logic                          release_slot_enable,
  output logic [SLOT_INDEX_WIDTH:0]     free_slot_count,
  output logic [DROP_COUNT_WIDTH-1:0]   dropped_packet_count,
  output logic                          protocol_error
);
  localparam int N = RECEIVE_QUE_SLOTS;
  localparam int SW = SLOT_INDEX_WIDTH;
  localparam int CW = $clog2(N+1);
  slot_state_type state [N];
  slot_state_type nxt [N];
  logic [N-1:0] push, rel_k, avail;
  logic [N-1:0][SW-1:0] lane_idx;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, pop, overflow, err_now;
  logic [DROP_COUNT_WIDTH-1:0] drop_next;
  int drops, npush, nfree, dsum;
  for (genvar g = 0; g < N; g++) assign lane_idx[g] = SW'(g);
  slot_index_fifo #(.DEPTH(N), .WIDTH(SW), .LANES(N)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .push_data(lane_idx),
    .pop(pop),
    .full(fifo_full),
    .empty(fifo_empty),
    .head(ready_slot),
    .count(fifo_count)
  );
  assign ready_slot_valid = !fifo_empty;
  assign pop = ready_slot_valid && ready_slot_ready;
  always_ff @(posedge clock)
    for (int k = 0; k < N; k++) state[k] <= reset ? S_SLOT_FREE : nxt[k];
  always_comb begin
    push = '0;
    rel_k = '0;
    avail = '0;
    drops = 0;
    npush = 0;
    nfree = 0;
    err_now = 1'b0;
    for (int k = 0; k < N; k++) begin
      nxt[k] = state[k];
      rel_k[k] = release_slot_enable && release_slot == SW'(k) && state[k] == S_SLOT_DRAINING;
      err_now = err_now || ((good_packet[k] || bad_packet[k]) && state[k] != S_SLOT_FILLING)
              || (good_packet[k] && bad_packet[k])
              || (packet_data_valid[k] && (state[k] == S_SLOT_READY || state[k] == S_SLOT_DRAINING));
      if (state[k] == S_SLOT_FREE && packet_data_valid[k]) nxt[k] = S_SLOT_FILLING;
      else if (state[k] == S_SLOT_FILLING && good_packet[k] && !bad_packet[k]) begin
        nxt[k] = S_SLOT_READY;
        push[k] = 1'b1;
      end else if (state[k] == S_SLOT_FILLING && bad_packet[k] && !good_packet[k]) begin
        nxt[k] = S_SLOT_FREE;
        drops = drops + 1;
      end else if (state[k] == S_SLOT_READY && pop && ready_slot == SW'(k)) nxt[k] = S_SLOT_DRAINING;
      else if (rel_k[k]) nxt[k] = S_SLOT_FREE;
      npush = npush + int'(push[k]);
      nfree = nfree + int'(state[k] == S_SLOT_FREE);
      // a slot being claimed this cycle is hidden from the next offer
      avail[k] = state[k] == S_SLOT_FREE && !packet_data_valid[k];
    end
    overflow = (fifo_full && !pop && |push) || (int'(fifo_count) + npush > N + int'(pop));
    err_now = err_now || (release_slot_enable && !(|rel_k)) || overflow;
    dsum = int'(dropped_packet_count) + drops;
    drop_next = dsum > (1 << DROP_COUNT_WIDTH) - 1 ? '1 : DROP_COUNT_WIDTH'(dsum);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      receive_slot_enable <= '0;
      free_slot_count <= '0;
      dropped_packet_count <= '0;
      protocol_error <= 1'b0;
    end else begin
      receive_slot_enable <= avail & (-avail);
      free_slot_count <= (SW+1)'(nfree);
      dropped_packet_count <= drop_next;
      protocol_error <= protocol_error || err_now;
    end
  end
endmodule

// File: tb/tb_ethernet_receive_slot_manager.sv
// tb_ethernet_receive_slot_manager: scoreboard bench for the receive slot manager
module tb_ethernet_receive_slot_manager;
  logic clock = 0;
  logic reset;
  logic [3:0] receive_slot_enable, packet_data_valid, good_packet, bad_packet;
  logic [1:0] ready_slot, release_slot;
  logic ready_slot_valid, ready_slot_ready, release_slot_enable;
  logic [2:0] free_slot_count;
  logic [15:0] dropped_packet_count;
  logic protocol_error;
  int total = 0;
  int bad = 0;
  logic [1:0] exp_q [$];
  ethernet_receive_slot_manager dut (
    .clock(clock),
    .reset(reset),
    .receive_slot_enable(receive_slot_enable),
    .packet_data_valid(packet_data_valid),
    .good_packet(good_packet),
    .bad_packet(bad_packet),
    .ready_slot(ready_slot),
    .ready_slot_valid(ready_slot_valid),
    .ready_slot_ready(ready_slot_ready),
    .release_slot(release_slot),
    .release_slot_enable(release_slot_enable),
    .free_slot_count(free_slot_count),
    .dropped_packet_count(dropped_packet_count),
    .protocol_error(protocol_error)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle_inputs();
    packet_data_valid = 0;
    good_packet = 0;
    bad_packet = 0;
    ready_slot_ready = 0;
    release_slot = 0;
    release_slot_enable = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    idle_inputs();
    exp_q.delete();
    repeat (2) step();
    reset = 0;
    step();
  endtask
  task automatic complete_good(input logic [3:0] m);
    good_packet = m;
    for (int i = 0; i < 4; i++) if (m[i]) exp_q.push_back(2'(i));
    step();
    good_packet = 0;
  endtask
  task automatic rel(input logic [1:0] s);
    release_slot = s;
    release_slot_enable = 1;
    step();
    release_slot_enable = 0;
  endtask
  task automatic pops(input int n);
    ready_slot_ready = 1;
    repeat (n) step();
    ready_slot_ready = 0;
  endtask
  always @(negedge clock)
    if (!reset && ready_slot_valid && ready_slot_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", {30'd0, ready_slot}, 32'hdead);
      else chk("pop_slot", {30'd0, ready_slot}, {30'd0, exp_q.pop_front()});
    end
  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) step();
    chk("rst_offer", receive_slot_enable, 0);
    chk("rst_valid", ready_slot_valid, 0);
    chk("rst_slot", ready_slot, 0);
    chk("rst_free", free_slot_count, 0);
    chk("rst_drop", dropped_packet_count, 0);
    chk("rst_err", protocol_error, 0);
    reset = 0;
    step();
    chk("idle_offer", receive_slot_enable, 4'b0001);
    chk("idle_free", free_slot_count, 4);
    chk("idle_valid", ready_slot_valid, 0);
    packet_data_valid = 4'b0001;
    step();
    chk("claim_offer", receive_slot_enable, 4'b0010);
    repeat (63) step();
    chk("fill_free", free_slot_count, 3);
    packet_data_valid = 0;
    complete_good(4'b0001);
    chk("good_valid", ready_slot_valid, 1);
    chk("good_slot", ready_slot, 0);
    pops(1);
    chk("pop_empty", ready_slot_valid, 0);
    rel(0);
    step();
    chk("rel_free", free_slot_count, 4);
    chk("rel_offer", receive_slot_enable, 4'b0001);
    packet_data_valid = 4'b0001;
    step();
    packet_data_valid = 0;
    bad_packet = 4'b0001;
    step();
    bad_packet = 0;
    step();
    chk("bad_offer", receive_slot_enable, 4'b0001);
    chk("bad_drop", dropped_packet_count, 1);
    chk("bad_valid", ready_slot_valid, 0);
    chk("bad_err", protocol_error, 0);
    packet_data_valid = 4'b0111;
    step();
    packet_data_valid = 0;
    complete_good(4'b0100);
    complete_good(4'b0001);
    complete_good(4'b0010);
    pops(3);
    step();
    chk("order_offer", receive_slot_enable, 4'b1000);
    chk("order_free", free_slot_count, 1);
    rel(2);
    rel(0);
    rel(1);
    step();
    chk("order_refree", free_slot_count, 4);
    packet_data_valid = 4'b1111;
    step();
    packet_data_valid = 0;
    complete_good(4'b1111);
    step();
    chk("full_offer", receive_slot_enable, 0);
    chk("full_free", free_slot_count, 0);
    chk("full_valid", ready_slot_valid, 1);
    pops(1);
    step();
    chk("full_pop_err", protocol_error, 0);
    chk("full_next_slot", ready_slot, 1);
    pops(3);
    for (int i = 0; i < 4; i++) rel(2'(i));
    step();
    chk("full_refree", free_slot_count, 4);
    chk("full_err_end", protocol_error, 0);
    chk("drop_keep", dropped_packet_count, 1);
    do_reset();
    chk("ill1_pre", protocol_error, 0);
    good_packet = 4'b1000;
    step();
    good_packet = 0;
    step();
    chk("ill1_err", protocol_error, 1);
    chk("ill1_free", free_slot_count, 4);
    chk("ill1_valid", ready_slot_valid, 0);
    chk("ill1_offer", receive_slot_enable, 4'b0001);
    do_reset();
    packet_data_valid = 4'b0010;
    step();
    packet_data_valid = 0;
    complete_good(4'b0010);
    step();
    chk("ill2_pre", protocol_error, 0);
    rel(1);
    step();
    chk("ill2_err", protocol_error, 1);
    chk("ill2_valid", ready_slot_valid, 1);
    chk("ill2_free", free_slot_count, 3);
    pops(1);
    do_reset();
    packet_data_valid = 4'b0010;
    step();
    packet_data_valid = 0;
    good_packet = 4'b0010;
    bad_packet = 4'b0010;
    step();
    idle_inputs();
    step();
    chk("ill3_err", protocol_error, 1);
    chk("ill3_valid", ready_slot_valid, 0);
    chk("ill3_drop", dropped_packet_count, 0);
    chk("ill3_free", free_slot_count, 3);
    complete_good(4'b0010);
    chk("ill3_still_filling", ready_slot_valid, 1);
    pops(1);
    step();
    chk("q_drained", exp_q.size(), 0);
    packet_data_valid = 4'b0001;
    repeat (2) step();
    do_reset();
    chk("midrst_offer", receive_slot_enable, 4'b0001);
    chk("midrst_free", free_slot_count, 4);
    chk("midrst_err", protocol_error, 0);
    chk("midrst_valid", ready_slot_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
